// File: rtl/alu_share_arbiter.sv
// ALU share arbiter: grants the integer ALU to execute or branch/AGU.
// Registers each result and returns it over a valid/ready response.
module alu_share_arbiter #(
  parameter int XLEN       = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_alu_op,
  input  logic [XLEN-1:0] req0_in1,
  input  logic [XLEN-1:0] req0_in2,
  input  logic [6:0]      req0_funct7,
  input  logic [4:0]      req0_shamt,
  input  logic            req0_is_r_type,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_alu_op,
  input  logic [XLEN-1:0] req1_in1,
  input  logic [XLEN-1:0] req1_in2,
  input  logic [6:0]      req1_funct7,
  input  logic [4:0]      req1_shamt,
  input  logic            req1_is_r_type,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_data,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_data,
  output logic [2:0]      alu_op,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [6:0]      alu_funct7,
  output logic [4:0]      alu_shamt,
  output logic            alu_is_r_type,
  input  logic [XLEN-1:0] alu_out,
  output logic            busy
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RESP = 1'b1;

  logic state;
  logic owner;
  logic last_grant;
  logic grant;
  logic grant_any;
  logic own_done;
  logic can_accept;
  logic accept;

  // Pick the winner; a tie goes to the requester not served last.
  always_comb begin
    grant_any = !rst && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) begin
      grant = FIXED_PRIO ? 1'b0 : ~last_grant;
    end else begin
      grant = req1_valid;
    end
  end

  // A new op may enter when idle or when the pending result leaves now.
  always_comb begin
    own_done = owner ? (rsp1_valid && rsp1_ready)
                     : (rsp0_valid && rsp0_ready);
    can_accept = (state == S_IDLE) || own_done;
    req0_ready = grant_any && can_accept
              && req0_valid && !grant;
    req1_ready = grant_any && can_accept
              && req1_valid && grant;
    accept = req0_ready || req1_ready;
  end

  // Steer the winner's operation onto the ALU; zeros when nobody asks.
  always_comb begin
    alu_op        = '0;
    alu_in1       = '0;
    alu_in2       = '0;
    alu_funct7    = '0;
    alu_shamt     = '0;
    alu_is_r_type = 1'b0;
    if (grant_any) begin
      if (grant) begin
        alu_op        = req1_alu_op;
        alu_in1       = req1_in1;
        alu_in2       = req1_in2;
        alu_funct7    = req1_funct7;
        alu_shamt     = req1_shamt;
        alu_is_r_type = req1_is_r_type;
      end else begin
        alu_op        = req0_alu_op;
        alu_in1       = req0_in1;
        alu_in2       = req0_in2;
        alu_funct7    = req0_funct7;
        alu_shamt     = req0_shamt;
        alu_is_r_type = req0_is_r_type;
      end
    end
  end

  // Response FSM: capture on accept, release on the owner's handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else if (accept) begin
      state      <= S_RESP;
      owner      <= grant;
      last_grant <= grant;
      rsp0_valid <= !grant;
      rsp1_valid <= grant;
    end else if (state == S_RESP && own_done) begin
      state      <= S_IDLE;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end
  end

  // Result registers only change when their requester is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_data <= '0;
      rsp1_data <= '0;
    end else if (accept) begin
      if (grant) rsp1_data <= alu_out;
      else       rsp0_data <= alu_out;
    end
  end

  assign busy = (state == S_RESP);

endmodule
